// File: rtl/seq_cla_adder.sv
// Sequential adder/subtractor: one carry-lookahead group of GW bits per clock,
// least significant group first, with a valid/ready handshake on each side.
module seq_cla_adder #(
    parameter int unsigned NBIT = 16,
    parameter int unsigned GW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] sum,
    output logic            cout,
    output logic            ovf,
    output logic            busy
);

    localparam int unsigned NG = NBIT / GW;
    localparam int unsigned KW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [NBIT-1:0] GMASK = NBIT'({GW{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NBIT-1:0] a_q, a_d;
    logic [NBIT-1:0] b_q, b_d;
    logic            c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic [NBIT-1:0] sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    int unsigned     base_c;
    logic [GW-1:0]   ga_c, gb_c, g_c, p_c, s_c;
    logic [GW:0]     gc_c;
    logic            cy_c, term_c;

    // Current group: every carry is a flat sum of products of g, p and the group carry-in.
    always_comb begin : group_cla
        cy_c   = 1'b0;
        term_c = 1'b0;
        base_c = GW * 32'(k_q);
        ga_c   = GW'(a_q >> base_c);
        gb_c   = GW'(b_q >> base_c);
        g_c    = ga_c & gb_c;
        p_c    = ga_c ^ gb_c;
        gc_c   = '0;
        gc_c[0] = c_q;
        for (int i = 0; i < int'(GW); i++) begin
            cy_c = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term_c = g_c[j];
                for (int m = j + 1; m <= i; m++) begin
                    term_c = term_c & p_c[m];
                end
                cy_c = cy_c | term_c;
            end
            term_c = c_q;
            for (int m = 0; m <= i; m++) begin
                term_c = term_c & p_c[m];
            end
            gc_c[i+1] = cy_c | term_c;
        end
        s_c = p_c ^ gc_c[GW-1:0];
    end

    // Next state and datapath updates.
    always_comb begin : next_state
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        k_d         = k_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = (sum_q & ~(GMASK << base_c)) | (NBIT'(s_c) << base_c);
                c_d   = gc_c[GW];
                if (k_q == KW'(NG - 1)) begin
                    cout_d  = gc_c[GW];
                    ovf_d   = gc_c[GW-1] ^ gc_c[GW];
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder: directed corner cases plus random traffic on GW=4, GW=16 and GW=1 builds,
// checked by a queue-based scoreboard fed from an arithmetic reference model.
module tb_seq_cla_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v, in_valid_v, in_ready_v, cin_v, sub_v;
    logic [2:0]  out_valid_v, out_ready_v, cout_v, ovf_v, busy_v;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic [15:0] sum_v [3];

    int rdy_mode;
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    seq_cla_adder #(.NBIT(16), .GW(4)) u_dut_g4 (
        .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .sum(sum_v[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));

    seq_cla_adder #(.NBIT(16), .GW(16)) u_dut_g16 (
        .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .sum(sum_v[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));

    seq_cla_adder #(.NBIT(16), .GW(1)) u_dut_g1 (
        .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .sum(sum_v[2]),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));

    function automatic void check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h (t=%0t)", nm, idx, act, exp, $time);
    endfunction

    function automatic int ng_of(int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 1 : 16;
    endfunction

    function automatic exp_t mk(logic [15:0] s, logic c, logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.acc = 0;
        return e;
    endfunction

    // Reference: plain integer add/subtract, overflow from operand and result signs.
    function automatic exp_t model(logic [15:0] x, logic [15:0] y, logic ci, logic s);
        exp_t e;
        logic [16:0] t;
        e.acc = 0;
        if (s) begin
            e.sum  = x - y;
            e.cout = (x >= y);
            e.ovf  = (x[15] != y[15]) && (e.sum[15] != x[15]);
        end else begin
            t      = 17'(x) + 17'(y) + 17'(ci);
            e.sum  = t[15:0];
            e.cout = t[16];
            e.ovf  = (x[15] == y[15]) && (e.sum[15] != x[15]);
        end
        return e;
    endfunction

    function automatic void q_push(int idx, exp_t e);
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_pop(int idx);
        case (idx)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_clear(int idx);
        case (idx)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive_now(int idx, logic [15:0] ai, logic [15:0] bi, logic ci, logic si, exp_t e);
        a_v[idx] = ai;
        b_v[idx] = bi;
        cin_v[idx] = ci;
        sub_v[idx] = si;
        in_valid_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[idx] = 1'b0;
        e.acc = cyc;
        q_push(idx, e);
    endtask

    task automatic issue(int idx, logic [15:0] ai, logic [15:0] bi, logic ci, logic si, exp_t e);
        int t = 0;
        @(negedge clk);
        while (!in_ready_v[idx] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            check("accept_timeout", idx, 32'(in_ready_v[idx]), 1);
            return;
        end
        drive_now(idx, ai, bi, ci, si, e);
    endtask

    task automatic wait_idle(int idx);
        int t = 0;
        @(negedge clk);
        while (!(in_ready_v[idx] && q_size(idx) == 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("drain_timeout", idx, 32'(q_size(idx)), 0);
    endtask

    task automatic wait_valid(int idx, logic lvl);
        int t = 0;
        @(negedge clk);
        while (out_valid_v[idx] !== lvl && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("out_valid_timeout", idx, 32'(out_valid_v[idx]), 32'(lvl));
    endtask

    task automatic run_random(int idx, int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] x, y;
            logic ci, si;
            x  = rnd_op();
            y  = rnd_op();
            ci = 1'($urandom_range(0, 1));
            si = 1'($urandom_range(0, 1));
            issue(idx, x, y, ci, si, model(x, y, ci, si));
        end
    endtask

    // Monitor: compares each new result with the scoreboard and checks it stays put until taken.
    task automatic monitor(int idx);
        exp_t e;
        bit   have;
        logic r;
        have = 1'b0;
        e = mk(16'h0, 1'b0, 1'b0);
        out_ready_v[idx] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_v[idx]) begin
                q_clear(idx);
                have = 1'b0;
                out_ready_v[idx] = 1'b0;
            end else begin
                if (out_valid_v[idx]) begin
                    if (!have) begin
                        have = 1'b1;
                        if (q_size(idx) == 0) begin
                            check("unexpected_out_valid", idx, 32'(out_valid_v[idx]), 0);
                            e = mk(sum_v[idx], cout_v[idx], ovf_v[idx]);
                        end else begin
                            e = q_pop(idx);
                            check("sum", idx, 32'(sum_v[idx]), 32'(e.sum));
                            check("cout", idx, 32'(cout_v[idx]), 32'(e.cout));
                            check("ovf", idx, 32'(ovf_v[idx]), 32'(e.ovf));
                            check("latency", idx, cyc, e.acc + ng_of(idx));
                        end
                    end else begin
                        check("hold_sum", idx, 32'(sum_v[idx]), 32'(e.sum));
                        check("hold_cout", idx, 32'(cout_v[idx]), 32'(e.cout));
                        check("hold_ovf", idx, 32'(ovf_v[idx]), 32'(e.ovf));
                        check("done_in_ready", idx, 32'(in_ready_v[idx]), 0);
                        check("done_busy", idx, 32'(busy_v[idx]), 1);
                    end
                end
                if (idx == 0 && rdy_mode == 1) r = 1'b0;
                else if (idx == 0 && rdy_mode == 2) r = 1'b1;
                else r = ($urandom_range(0, 3) != 0);
                out_ready_v[idx] = r;
                if (out_valid_v[idx] && r) have = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    initial begin
        #1500000;
        $display("FAIL watchdog dut0: got cycle %0d, want finish before it", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v = '1;
        in_valid_v = '0;
        cin_v = '0;
        sub_v = '0;
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", i, 32'(in_ready_v[i]), 1);
            check("rst_out_valid", i, 32'(out_valid_v[i]), 0);
            check("rst_busy", i, 32'(busy_v[i]), 0);
            check("rst_sum", i, 32'(sum_v[i]), 0);
            check("rst_cout", i, 32'(cout_v[i]), 0);
            check("rst_ovf", i, 32'(ovf_v[i]), 0);
        end

        // Accept on the very first edge after reset release.
        rst_v = '0;
        drive_now(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        check("accept_first_edge", 0, 32'(busy_v[0]), 1);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        wait_idle(0);

        // Back-pressure in DONE while new operands are offered.
        @(posedge clk);
        #1;
        rdy_mode = 1;
        issue(0, 16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0));
        wait_valid(0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("stall_in_ready", 0, 32'(in_ready_v[0]), 0);
            a_v[0] = 16'hFFFF;
            b_v[0] = 16'hFFFF;
            cin_v[0] = 1'b1;
            sub_v[0] = 1'b0;
            in_valid_v[0] = 1'b1;
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rdy_mode = 2;
        wait_valid(0, 1'b0);
        check("release_in_ready", 0, 32'(in_ready_v[0]), 1);
        check("release_busy", 0, 32'(busy_v[0]), 0);
        check("idle_keeps_sum", 0, 32'(sum_v[0]), 32'h5556);
        check("idle_queue_empty", 0, 32'(q_size(0)), 0);

        // Reset between the first and second RUN edges aborts the operation.
        issue(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, model(16'h00FF, 16'h0F01, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        #1;
        check("abort_in_ready", 0, 32'(in_ready_v[0]), 1);
        check("abort_busy", 0, 32'(busy_v[0]), 0);
        @(negedge clk);
        @(negedge clk);
        check("abort_sum", 0, 32'(sum_v[0]), 0);
        check("abort_cout", 0, 32'(cout_v[0]), 0);
        check("abort_ovf", 0, 32'(ovf_v[0]), 0);
        check("abort_out_valid", 0, 32'(out_valid_v[0]), 0);
        rst_v[0] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_result", 0, 32'(out_valid_v[0]), 0);
        end
        issue(0, 16'hABCD, 16'h1234, 1'b1, 1'b0, model(16'hABCD, 16'h1234, 1'b1, 1'b0));
        wait_idle(0);

        @(posedge clk);
        #1;
        rdy_mode = 0;
        fork
            run_random(0, 10000);
            run_random(1, 2000);
            run_random(2, 2000);
        join
        for (int i = 0; i < 3; i++) wait_idle(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_cla_adder.md
SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

Interface
REQ-001 The block SHALL take parameter NBIT, default 16, giving the adder operand width in bits.
REQ-002 The block SHALL take parameter GW, default 4, giving the group width in bits; NBIT SHALL be an integer multiple of GW, and any other combination is illegal.
REQ-003 The block SHALL derive local parameter NG = NBIT/GW, the number of groups.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a, b  input  NBIT each  operands.
REQ-009 cin  input  1  carry in; used only when sub=0.
REQ-010 sub  input  1  0 selects a+b+cin; 1 selects a-b.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  NBIT  result.
REQ-014 cout  output  1  carry out of bit NBIT-1.
REQ-015 ovf  output  1  signed overflow.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-019 On an edge with in_valid=1 in IDLE, the block SHALL capture the operands, clear group index k to 0 and enter RUN:
- sub=0: capture a, b and cin.
- sub=1: capture a, ~b and carry 1; cin is ignored.
REQ-020 In RUN, each edge SHALL process exactly one group k (bits k*GW .. k*GW+GW-1), least significant group first.
REQ-021 Within a group, per-bit generate g=a&b and propagate p=a^b SHALL be formed.
REQ-022 Every internal carry of a group SHALL be a flattened sum-of-products of g, p and the group carry-in (lookahead form, no bit-to-bit ripple).
REQ-023 Each group SHALL write sum bits p^c into its slice of the sum register and register the group carry-out as the next group's carry-in.
REQ-024 On the edge processing group NG-1, the block SHALL:
- register cout as the carry out of bit NBIT-1;
- register ovf as (carry into bit NBIT-1) XOR (carry out of bit NBIT-1);
- enter DONE.
REQ-025 out_valid SHALL be 1 exactly in DONE, rising NG edges after the accepting edge.
REQ-026 In DONE, sum, cout and ovf SHALL be held stable until the handshake edge; on out_valid=1 and out_ready=1 the block SHALL return to IDLE.
REQ-027 sum, cout and ovf SHALL retain their last values in IDLE until the next acceptance.
REQ-028 Intermediate sum slices SHALL NOT be observable as valid: out_valid SHALL remain 0 throughout RUN.
REQ-029 Peak throughput SHALL be one operation per NG+2 cycles (accept, NG RUN edges, handshake); input and output transactions never overlap.
REQ-030 For NG=1, RUN SHALL last exactly one edge.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with outputs in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, and all internal operand, carry and k registers at 0.
REQ-032 Asserting rst in RUN or DONE SHALL abort the operation immediately with no result delivered.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept operands.

Verification (NBIT=16, GW=4)
REQ-034 The bench SHALL cover a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, with out_valid rising exactly 4 edges after acceptance.
REQ-035 The bench SHALL cover a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 The bench SHALL cover a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored); and a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-037 The bench SHALL hold out_ready=0 for 10 cycles in DONE while driving new in_valid with other operands -> sum, cout, ovf unchanged, in_ready=0, new operands never captured; a single out_ready pulse returns the block to IDLE.
REQ-038 The bench SHALL assert rst during the second RUN edge -> out_valid never rises, sum=0, in_ready=1; a fresh operation afterwards completes correctly.
REQ-039 The bench SHALL run 10,000 random operand/sub/cin sets with random out_ready, plus NG=1 (GW=16) and GW=1 builds -> every result matches a reference model.
